// File: rtl/div_issue_ctrl_pkg.sv
// rtl/div_issue_ctrl_pkg.sv - shared constants, op bit indices and FSM states for the divide issue controller
package div_issue_ctrl_pkg;

  localparam int DIV_DATA_W = 32;
  localparam int DIV_REG_AW = 5;

  localparam int OP_DIV  = 3;
  localparam int OP_DIVU = 2;
  localparam int OP_REM  = 1;
  localparam int OP_REMU = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_BUSY = 3'b010,
    ST_DONE = 3'b100
  } state_t;

  // True when exactly one op bit is set; zero or multi-bit ops are not divisions.
  function automatic logic op_onehot(input logic [3:0] op);
    return (op != 4'd0) && ((op & (op - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/div_issue_ctrl_if.sv
// rtl/div_issue_ctrl_if.sv - start/op/operand/result handshake between issue controller and iterative divider
interface div_issue_ctrl_if;
  import div_issue_ctrl_pkg::*;

  logic                  div_start_o;
  logic [3:0]            div_op_o;
  logic [DIV_DATA_W-1:0] div_dividend_o;
  logic [DIV_DATA_W-1:0] div_divisor_o;
  logic [DIV_DATA_W-1:0] div_result_i;
  logic                  div_ready_i;

  modport master (
    output div_start_o, div_op_o, div_dividend_o, div_divisor_o,
    input  div_result_i, div_ready_i
  );

  modport slave (
    input  div_start_o, div_op_o, div_dividend_o, div_divisor_o,
    output div_result_i, div_ready_i
  );

endinterface

// File: rtl/div_issue_ctrl_reuse_cache.sv
// rtl/div_issue_ctrl_reuse_cache.sv - single-entry record of the last completed divide (built only with DIV_REUSE_EN)
`ifdef DIV_REUSE_EN
module div_reuse_cache
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_en,
  input  logic [3:0]        rec_op,
  input  logic [DATA_W-1:0] rec_dividend,
  input  logic [DATA_W-1:0] rec_divisor,
  input  logic [DATA_W-1:0] rec_result,
  input  logic [3:0]        lk_op,
  input  logic [DATA_W-1:0] lk_dividend,
  input  logic [DATA_W-1:0] lk_divisor,
  output logic              hit,
  output logic [DATA_W-1:0] hit_result
);

  logic              valid_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [DATA_W-1:0] result_q;

  // Capture the operation that just completed; flushed ones never assert rec_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
    end else if (rec_en) begin
      valid_q    <= 1'b1;
      op_q       <= rec_op;
      dividend_q <= rec_dividend;
      divisor_q  <= rec_divisor;
      result_q   <= rec_result;
    end
  end

  assign hit = valid_q && (lk_op == op_q) && (lk_dividend == dividend_q) && (lk_divisor == divisor_q);
  assign hit_result = result_q;

endmodule
`endif

// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage issue/stall/writeback control for the iterative divider; DIV_REUSE_EN adds last-result reuse
module div_issue_ctrl
  import div_issue_ctrl_pkg::*;
#(
  parameter int DATA_W = DIV_DATA_W,
  parameter int REG_AW = DIV_REG_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic [3:0]        op_i,
  input  logic [DATA_W-1:0] dividend_i,
  input  logic [DATA_W-1:0] divisor_i,
  input  logic [REG_AW-1:0] rd_addr_i,
  input  logic              flush_i,
  div_issue_ctrl_if.master  div,
  output logic              hold_o,
  output logic              busy_o,
  output logic              wb_we_o,
  output logic [REG_AW-1:0] wb_addr_o,
  output logic [DATA_W-1:0] wb_data_o
);

  state_t            state_q, state_d;
  logic              accept;
  logic              reuse_hit;
  logic [DATA_W-1:0] reuse_result;
  logic              start_q;
  logic [3:0]        op_q;
  logic [DATA_W-1:0] dividend_q;
  logic [DATA_W-1:0] divisor_q;
  logic [REG_AW-1:0] rd_q;

  assign accept = (state_q == ST_IDLE) && req_i && op_onehot(op_i) && !flush_i;

`ifdef DIV_REUSE_EN
  div_reuse_cache #(.DATA_W(DATA_W)) u_reuse (
    .clk          (clk),
    .rst_n        (rst_n),
    .rec_en       ((state_q == ST_BUSY) && div.div_ready_i && !flush_i),
    .rec_op       (op_q),
    .rec_dividend (dividend_q),
    .rec_divisor  (divisor_q),
    .rec_result   (div.div_result_i),
    .lk_op        (op_i),
    .lk_dividend  (dividend_i),
    .lk_divisor   (divisor_i),
    .hit          (reuse_hit),
    .hit_result   (reuse_result)
  );
`else
  assign reuse_hit    = 1'b0;
  assign reuse_result = '0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state plus the combinational stall and busy indications.
  always_comb begin
    state_d = state_q;
    hold_o  = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        hold_o = accept;
        if (accept) state_d = reuse_hit ? ST_DONE : ST_BUSY;
      end
      ST_BUSY: begin
        hold_o = 1'b1;
        busy_o = 1'b1;
        if (flush_i)               state_d = ST_IDLE;
        else if (div.div_ready_i)  state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand capture, start hold/drop and the one-cycle writeback pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q    <= 1'b0;
      op_q       <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      rd_q       <= '0;
      wb_we_o    <= 1'b0;
      wb_addr_o  <= '0;
      wb_data_o  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            op_q       <= op_i;
            dividend_q <= dividend_i;
            divisor_q  <= divisor_i;
            rd_q       <= rd_addr_i;
            start_q    <= !reuse_hit;
            if (reuse_hit) begin
              wb_data_o <= reuse_result;
              wb_addr_o <= rd_addr_i;
              wb_we_o   <= (rd_addr_i != '0);
            end
          end
        end
        ST_BUSY: begin
          if (flush_i) begin
            start_q <= 1'b0;
          end else if (div.div_ready_i) begin
            // Start must fall on this edge or the divider begins a new pass.
            start_q   <= 1'b0;
            wb_data_o <= div.div_result_i;
            wb_addr_o <= rd_q;
            wb_we_o   <= (rd_q != '0);
          end
        end
        ST_DONE: wb_we_o <= 1'b0;
        default: start_q <= 1'b0;
      endcase
    end
  end

  assign div.div_start_o    = start_q;
  assign div.div_op_o       = op_q;
  assign div.div_dividend_o = dividend_q;
  assign div.div_divisor_o  = divisor_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - directed self-checking bench for div_issue_ctrl
module tb_div_issue_ctrl;

  logic        clk;
  logic        rst_n;
  logic        req_i;
  logic [3:0]  op_i;
  logic [31:0] dividend_i;
  logic [31:0] divisor_i;
  logic [4:0]  rd_addr_i;
  logic        flush_i;
  logic        hold_o;
  logic        busy_o;
  logic        wb_we_o;
  logic [4:0]  wb_addr_o;
  logic [31:0] wb_data_o;

  int n_cmp = 0;
  int n_err = 0;

  div_issue_ctrl_if dif();

  div_issue_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_i      (req_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .rd_addr_i  (rd_addr_i),
    .flush_i    (flush_i),
    .div        (dif),
    .hold_o     (hold_o),
    .busy_o     (busy_o),
    .wb_we_o    (wb_we_o),
    .wb_addr_o  (wb_addr_o),
    .wb_data_o  (wb_data_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Full divider path; called at a negedge with the DUT in IDLE, returns at the first IDLE negedge after DONE.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input int n_busy, input logic [31:0] res);
    logic exp_we;
    exp_we     = (rd != 5'd0);
    req_i      = 1'b1;
    op_i       = op;
    dividend_i = a;
    divisor_i  = b;
    rd_addr_i  = rd;
    flush_i    = 1'b0;
    #1;
    check({tag, "_accept_hold"}, hold_o, 1);
    check({tag, "_accept_start"}, dif.div_start_o, 0);
    @(negedge clk);
    check({tag, "_op"}, dif.div_op_o, op);
    check({tag, "_dividend"}, dif.div_dividend_o, a);
    check({tag, "_divisor"}, dif.div_divisor_o, b);
    for (int i = 0; i < n_busy; i++) begin
      check({tag, "_busy_start_hold_busy"}, {dif.div_start_o, hold_o, busy_o}, 3'b111);
      check({tag, "_busy_no_we"}, wb_we_o, 0);
      if (i == n_busy - 1) begin
        dif.div_ready_i  = 1'b1;
        dif.div_result_i = res;
      end
      @(negedge clk);
    end
    check({tag, "_done_start"}, dif.div_start_o, 0);
    check({tag, "_done_we"}, wb_we_o, exp_we);
    check({tag, "_done_addr"}, wb_addr_o, rd);
    check({tag, "_done_data"}, wb_data_o, res);
    check({tag, "_done_hold"}, hold_o, 0);
    check({tag, "_done_busy"}, busy_o, 0);
    @(negedge clk);
    dif.div_ready_i  = 1'b0;
    dif.div_result_i = 32'd0;
    check({tag, "_idle_we"}, wb_we_o, 0);
    check({tag, "_idle_start"}, dif.div_start_o, 0);
  endtask

  initial begin
    rst_n            = 1'b0;
    req_i            = 1'b0;
    op_i             = 4'd0;
    dividend_i       = 32'd0;
    divisor_i        = 32'd0;
    rd_addr_i        = 5'd0;
    flush_i          = 1'b0;
    dif.div_ready_i  = 1'b0;
    dif.div_result_i = 32'd0;

    @(negedge clk);
    @(negedge clk);
    check("rst_start", dif.div_start_o, 0);
    check("rst_hold", hold_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_we", wb_we_o, 0);
    check("rst_data", wb_data_o, 0);
    check("rst_operands", {dif.div_op_o, dif.div_dividend_o[3:0], dif.div_divisor_o[3:0]}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // DIV 100 / -7 -> -14
    do_op("div_neg", 4'b1000, 32'd100, 32'hFFFF_FFF9, 5'd5, 35, 32'hFFFF_FFF2);
    // REMU 0xFFFFFFFF % 0 -> dividend
    do_op("remu_zero", 4'b0001, 32'hFFFF_FFFF, 32'd0, 5'd3, 2, 32'hFFFF_FFFF);
    // DIVU x / 0 -> all ones
    do_op("divu_zero", 4'b0100, 32'h0000_1234, 32'd0, 5'd6, 2, 32'hFFFF_FFFF);
    req_i = 1'b0;
    #1;
    check("idle_hold", hold_o, 0);

    // Ready in IDLE with no request must do nothing.
    @(negedge clk);
    dif.div_ready_i  = 1'b1;
    dif.div_result_i = 32'hDEAD_BEEF;
    @(negedge clk);
    dif.div_ready_i  = 1'b0;
    check("stale_ready_we", wb_we_o, 0);
    check("stale_ready_start", dif.div_start_o, 0);
    check("stale_ready_busy", busy_o, 0);

    // Flush on the 10th BUSY cycle, simultaneous with ready: flush wins.
    req_i      = 1'b1;
    op_i       = 4'b1000;
    dividend_i = 32'd1000;
    divisor_i  = 32'd3;
    rd_addr_i  = 5'd7;
    #1;
    check("flush_accept_hold", hold_o, 1);
    @(negedge clk);
    for (int i = 1; i < 10; i++) begin
      check("flush_busy", {dif.div_start_o, busy_o}, 2'b11);
      @(negedge clk);
    end
    check("flush_busy10_start", dif.div_start_o, 1);
    flush_i          = 1'b1;
    dif.div_ready_i  = 1'b1;
    dif.div_result_i = 32'h1234_5678;
    @(negedge clk);
    check("flush_start_low", dif.div_start_o, 0);
    check("flush_no_we", wb_we_o, 0);
    check("flush_busy_low", busy_o, 0);
    req_i           = 1'b0;
    flush_i         = 1'b0;
    dif.div_ready_i = 1'b0;
    #1;
    check("flush_idle_hold", hold_o, 0);
    @(negedge clk);
    check("flush_after_we", wb_we_o, 0);
    check("flush_after_start", dif.div_start_o, 0);

    // REM -9 % 4 -> -1
    do_op("rem_neg", 4'b0010, 32'hFFFF_FFF7, 32'd4, 5'd9, 35, 32'hFFFF_FFFF);

    // Back-to-back DIVU 50/5 then DIV 50/5
    do_op("b2b_divu", 4'b0100, 32'd50, 32'd5, 5'd1, 35, 32'd10);
    do_op("b2b_div", 4'b1000, 32'd50, 32'd5, 5'd2, 35, 32'd10);

    // Repeat of an identical DIVU: reuse path when the record is enabled.
    do_op("divu_rec", 4'b0100, 32'd50, 32'd5, 5'd4, 35, 32'd10);
`ifdef DIV_REUSE_EN
    req_i      = 1'b1;
    op_i       = 4'b0100;
    dividend_i = 32'd50;
    divisor_i  = 32'd5;
    rd_addr_i  = 5'd4;
    #1;
    check("reuse_accept_hold", hold_o, 1);
    @(negedge clk);
    check("reuse_start", dif.div_start_o, 0);
    check("reuse_busy", busy_o, 0);
    check("reuse_we", wb_we_o, 1);
    check("reuse_addr", wb_addr_o, 5'd4);
    check("reuse_data", wb_data_o, 32'd10);
    check("reuse_hold", hold_o, 0);
    @(negedge clk);
    check("reuse_idle_we", wb_we_o, 0);
    check("reuse_idle_start", dif.div_start_o, 0);
`else
    do_op("divu_rep", 4'b0100, 32'd50, 32'd5, 5'd4, 35, 32'd10);
`endif
    do_op("divu_new", 4'b0100, 32'd50, 32'd6, 5'd4, 35, 32'd8);

    // Non-one-hot and zero ops are ignored.
    req_i = 1'b1;
    op_i  = 4'b0110;
    #1;
    check("bad_op_hold", hold_o, 0);
    @(negedge clk);
    check("bad_op_start", dif.div_start_o, 0);
    check("bad_op_busy", busy_o, 0);
    op_i = 4'b0000;
    #1;
    check("zero_op_hold", hold_o, 0);
    @(negedge clk);
    check("zero_op_start", dif.div_start_o, 0);

    // rd = 0: full sequence, write enable suppressed.
    do_op("rd_zero", 4'b1000, 32'd77, 32'd7, 5'd0, 35, 32'd11);

    // Reset in the middle of a divide drops start at once.
    req_i      = 1'b1;
    op_i       = 4'b1000;
    dividend_i = 32'd5;
    divisor_i  = 32'd1;
    rd_addr_i  = 5'd8;
    @(negedge clk);
    @(negedge clk);
    check("midrst_busy_before", dif.div_start_o, 1);
    req_i = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_start", dif.div_start_o, 0);
    check("midrst_busy", busy_o, 0);
    check("midrst_we", wb_we_o, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_after_start", dif.div_start_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
